// File: rtl/config_bitstream_loader_pkg.sv
// Shared types and defaults for the configuration bitstream loader.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package config_bitstream_loader_pkg;

  // Default configuration word width: 8 IO groups x 2 select bits.
  localparam int IO_GROUPS       = 8;
  localparam int DEF_WORD_W      = IO_GROUPS * 2;
  localparam int DEF_ACK_TIMEOUT = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_e;

endpackage

// File: rtl/config_bitstream_loader.sv
// Serialises one configuration word LSB-first into the IO chain and waits for its acknowledge.
// Latency: start to done is 1 + WORD_W + (1..ACK_TIMEOUT) + 1 cycles, minimum WORD_W+3.
// Backpressure: start is only accepted in IDLE or ERR; it is ignored while a load is in flight.
module config_bitstream_loader
  import config_bitstream_loader_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_word,
  output logic              prgm_b,
  output logic              io_prgm_b,
  output logic              io_prgm_b_in,
  output logic              bit_out,
  input  logic              io_prgm_b_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = $clog2(WORD_W) + 1;
  localparam int WAIT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                ack_seen_q, ack_seen_d;

  logic prgm_b_q, prgm_b_d;
  logic io_prgm_b_q, io_prgm_b_d;
  logic io_prgm_b_in_q, io_prgm_b_in_d;
  logic bit_out_q, bit_out_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  // Next-state, datapath and output decode; outputs follow the state being entered so they register in step with it.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ack_seen_d = ack_seen_q;

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          shift_d    = cfg_word;
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          ack_seen_d = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (io_prgm_b_out) ack_seen_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // An early acknowledge is remembered so WAIT_ACK can exit immediately.
        if (io_prgm_b_out) ack_seen_d = 1'b1;
        shift_d = shift_q >> 1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = WAIT_ACK;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (io_prgm_b_out || ack_seen_q) begin
          state_d = DONE;
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    prgm_b_d       = 1'b1;
    io_prgm_b_d    = 1'b0;
    io_prgm_b_in_d = 1'b0;
    bit_out_d      = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;

    case (state_d)
      SETUP: begin
        prgm_b_d    = 1'b0;
        io_prgm_b_d = 1'b1;
        busy_d      = 1'b1;
      end
      SHIFT: begin
        prgm_b_d       = 1'b0;
        io_prgm_b_d    = 1'b1;
        io_prgm_b_in_d = 1'b1;
        bit_out_d      = shift_d[0];
        busy_d         = 1'b1;
      end
      WAIT_ACK: begin
        prgm_b_d    = 1'b0;
        io_prgm_b_d = 1'b1;
        busy_d      = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counters, shift register and registered outputs; reset wins over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      ack_seen_q     <= 1'b0;
      prgm_b_q       <= 1'b1;
      io_prgm_b_q    <= 1'b0;
      io_prgm_b_in_q <= 1'b0;
      bit_out_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      ack_seen_q     <= ack_seen_d;
      prgm_b_q       <= prgm_b_d;
      io_prgm_b_q    <= io_prgm_b_d;
      io_prgm_b_in_q <= io_prgm_b_in_d;
      bit_out_q      <= bit_out_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign prgm_b       = prgm_b_q;
  assign io_prgm_b    = io_prgm_b_q;
  assign io_prgm_b_in = io_prgm_b_in_q;
  assign bit_out      = bit_out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Directed bench for the configuration bitstream loader with a 16-bit IO chain model.
// Latency: each scenario steps cycle by cycle from the start edge.
// Backpressure: acknowledge is driven by the bench at chosen cycles.
module tb_config_bitstream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_word;
  logic        prgm_b;
  logic        io_prgm_b;
  logic        io_prgm_b_in;
  logic        bit_out;
  logic        io_prgm_b_out;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] chain = 16'h0000;

  config_bitstream_loader #(.WORD_W(16), .ACK_TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_word     (cfg_word),
    .prgm_b       (prgm_b),
    .io_prgm_b    (io_prgm_b),
    .io_prgm_b_in (io_prgm_b_in),
    .bit_out      (bit_out),
    .io_prgm_b_out(io_prgm_b_out),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // IO chain model: each shift-enabled cycle pushes bit_in in from the top, so the first bit ends at chain[0].
  always @(posedge clk) begin
    if (io_prgm_b_in) chain <= {bit_out, chain[15:1]};
  end

  // Count done pulses over the whole run.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cfg_word = 16'h0000; io_prgm_b_out = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (prgm_b !== 1'b1) begin errors++; $display("FAIL reset_prgm_b got %b want 1", prgm_b); end
    checks++;
    if (io_prgm_b !== 1'b0) begin errors++; $display("FAIL reset_io_prgm_b got %b want 0", io_prgm_b); end
    checks++;
    if ({io_prgm_b_in, bit_out} !== 2'b00) begin errors++; $display("FAIL reset_shift_outs got %b want 00", {io_prgm_b_in, bit_out}); end
    checks++;
    if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {busy, done, err}); end
    tick();
  endtask

  task automatic test_load_ack();
    bit exp_seq [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int d0;
    d0 = done_cnt;
    cfg_word = 16'hA5C3; start = 1'b1;
    tick();
    start = 1'b0; cfg_word = 16'h0000;
    checks++;
    if ({prgm_b, io_prgm_b, io_prgm_b_in, busy} !== 4'b0101) begin
      errors++; $display("FAIL setup_outs got %b want 0101", {prgm_b, io_prgm_b, io_prgm_b_in, busy});
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({io_prgm_b_in, bit_out} !== {1'b1, exp_seq[i]}) begin
        errors++; $display("FAIL shift_bit_%0d got %b want %b", i, {io_prgm_b_in, bit_out}, {1'b1, exp_seq[i]});
      end
    end
    tick();
    checks++;
    if ({prgm_b, io_prgm_b, io_prgm_b_in, bit_out, busy, done} !== 6'b010010) begin
      errors++; $display("FAIL wait_ack_outs got %b want 010010", {prgm_b, io_prgm_b, io_prgm_b_in, bit_out, busy, done});
    end
    io_prgm_b_out = 1'b1;
    tick();
    io_prgm_b_out = 1'b0;
    checks++;
    if ({done, busy, prgm_b, io_prgm_b} !== 4'b1110) begin
      errors++; $display("FAIL done_cycle19 got %b want 1110", {done, busy, prgm_b, io_prgm_b});
    end
    checks++;
    if (chain[15:14] !== 2'b10) begin errors++; $display("FAIL g0_s0 got %b want 10", chain[15:14]); end
    checks++;
    if (chain[1:0] !== 2'b11) begin errors++; $display("FAIL g7_s7 got %b want 11", chain[1:0]); end
    tick();
    checks++;
    if ({done, busy, prgm_b} !== 3'b001) begin errors++; $display("FAIL after_done got %b want 001", {done, busy, prgm_b}); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_cnt;
    cfg_word = 16'h00FF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    for (int w = 0; w < 8; w++) begin
      tick();
      checks++;
      if ({busy, err, done} !== 3'b100) begin
        errors++; $display("FAIL wait_%0d got %b want 100", w, {busy, err, done});
      end
    end
    tick();
    checks++;
    if ({err, busy, prgm_b, io_prgm_b} !== 4'b1010) begin
      errors++; $display("FAIL timeout_err got %b want 1010", {err, busy, prgm_b, io_prgm_b});
    end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL timeout_no_done got %0d want %0d", done_cnt, d0); end
    cfg_word = 16'h0F0F; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({err, busy} !== 2'b01) begin errors++; $display("FAIL restart_clear_err got %b want 01", {err, busy}); end
    repeat (17) tick();
    io_prgm_b_out = 1'b1;
    tick();
    io_prgm_b_out = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done); end
    checks++;
    if (chain !== 16'h0F0F) begin errors++; $display("FAIL restart_chain got %h want 0f0f", chain); end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int d0;
    d0 = done_cnt;
    cfg_word = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if (io_prgm_b_in !== 1'b1) begin errors++; $display("FAIL mid_shift_active got %b want 1", io_prgm_b_in); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({prgm_b, io_prgm_b, io_prgm_b_in, bit_out, busy, done, err} !== 7'b1000000) begin
      errors++; $display("FAIL abort_reset_vals got %b want 1000000", {prgm_b, io_prgm_b, io_prgm_b_in, bit_out, busy, done, err});
    end
    repeat (25) tick();
    checks++;
    if ({busy, done_cnt == d0} !== 2'b01) begin
      errors++; $display("FAIL abort_no_done busy=%b done_cnt=%0d want busy=0 done_cnt=%0d", busy, done_cnt, d0);
    end
    cfg_word = 16'h8001; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    io_prgm_b_out = 1'b1;
    tick();
    io_prgm_b_out = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL post_abort_done got %b want 1", done); end
    checks++;
    if (chain !== 16'h8001) begin errors++; $display("FAIL post_abort_chain got %h want 8001", chain); end
    tick();
  endtask

  task automatic test_ignore_start_early_ack();
    bit exp_seq [16] = '{0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0};
    cfg_word = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 4) start = 1'b0;
      if (i == 11) io_prgm_b_out = 1'b0;
      checks++;
      if (bit_out !== exp_seq[i]) begin
        errors++; $display("FAIL ignore_bit_%0d got %b want %b", i, bit_out, exp_seq[i]);
      end
      if (i == 3) begin start = 1'b1; cfg_word = 16'hFFFF; end
      if (i == 10) io_prgm_b_out = 1'b1;
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL early_ack_wait got %b want 10", {busy, done}); end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL early_ack_done got %b want 1", done); end
    checks++;
    if (chain !== 16'h1234) begin errors++; $display("FAIL ignore_chain got %h want 1234", chain); end
    repeat (2) tick();
    checks++;
    if ({busy, prgm_b} !== 2'b01) begin errors++; $display("FAIL ignore_idle got %b want 01", {busy, prgm_b}); end
  endtask

  task automatic test_start_with_reset();
    cfg_word = 16'hAAAA; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    checks++;
    if ({busy, prgm_b, io_prgm_b} !== 3'b010) begin
      errors++; $display("FAIL start_reset_idle got %b want 010", {busy, prgm_b, io_prgm_b});
    end
    tick();
    checks++;
    if ({busy, prgm_b, io_prgm_b_in} !== 3'b010) begin
      errors++; $display("FAIL start_reset_stay got %b want 010", {busy, prgm_b, io_prgm_b_in});
    end
  endtask

  initial begin
    test_reset();
    test_load_ack();
    test_timeout();
    test_reset_mid_shift();
    test_ignore_start_early_ack();
    test_start_with_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/config_bitstream_loader.md
CONFIG_BITSTREAM_LOADER -- requirements
Module: config_bitstream_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16: number of configuration bits per IO chain load (8 IO groups x 2 select bits).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 8: maximum number of cycles to wait for the chain-done acknowledge.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to load one configuration word.
REQ-006 The block SHALL have port cfg_word, input, WORD_W bits: configuration word, sampled on an accepted start.
REQ-007 The block SHALL have port prgm_b, output, 1 bit: global program strobe, active low.
REQ-008 The block SHALL have port io_prgm_b, output, 1 bit: IO chain select, active high.
REQ-009 The block SHALL have port io_prgm_b_in, output, 1 bit: shift-enable token to the IO chain.
REQ-010 The block SHALL have port bit_out, output, 1 bit: serial configuration bit, which drives the chain's bit_in.
REQ-011 The block SHALL have port io_prgm_b_out, input, 1 bit: chain-loaded acknowledge returned by the IO chain.
REQ-012 The block SHALL have port busy, output, 1 bit: high from start acceptance until the return to IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 The block SHALL have port err, output, 1 bit: sticky acknowledge-timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, SHIFT, WAIT_ACK, DONE and ERR.
REQ-016 In IDLE or ERR, start=1 SHALL capture cfg_word into the shift register, clear err, zero the bit counter, set busy and enter SETUP.
REQ-017 start SHALL be ignored in SETUP, SHIFT, WAIT_ACK and DONE.
REQ-018 SETUP SHALL last exactly 1 cycle with prgm_b=0, io_prgm_b=1 and io_prgm_b_in=0, giving the chain one cycle of setup before shifting.
REQ-019 SHIFT SHALL last exactly WORD_W cycles with prgm_b=0, io_prgm_b=1, io_prgm_b_in=1 and bit_out=shift_reg[0].
REQ-020 In SHIFT, the shift register SHALL shift right by one bit each cycle, so cfg_word[0] is sent first and cfg_word[WORD_W-1] last.
REQ-021 The bit counter SHALL be $clog2(WORD_W)+1 bits wide; SHIFT SHALL exit to WAIT_ACK when the counter reaches WORD_W-1, with no wrap-around.
REQ-022 With the default parameters, the resulting chain mapping SHALL be Gk_Sk = {cfg_word[15-2k], cfg_word[14-2k]}, i.e. G0_S0 = cfg_word[15:14] and G7_S7 = cfg_word[1:0].
REQ-023 WAIT_ACK SHALL hold prgm_b=0 and io_prgm_b=1, drive io_prgm_b_in=0 and bit_out=0, and count waiting cycles.
REQ-024 In WAIT_ACK, io_prgm_b_out=1 SHALL move the FSM to DONE.
REQ-025 In WAIT_ACK, ACK_TIMEOUT cycles without io_prgm_b_out=1 SHALL move the FSM to ERR.
REQ-026 io_prgm_b_out=1 already high during SETUP or SHIFT SHALL be recorded and SHALL let WAIT_ACK exit to DONE on its first cycle.
REQ-027 DONE SHALL last 1 cycle with done=1, prgm_b=1, io_prgm_b=0 and busy=1, and SHALL then go to IDLE.
REQ-028 ERR SHALL set err=1 and busy=0, and SHALL release prgm_b=1 and io_prgm_b=0; err SHALL stay set until the next accepted start or reset.
REQ-029 In IDLE, the block SHALL drive prgm_b=1, io_prgm_b=0, io_prgm_b_in=0, bit_out=0 and busy=0.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-031 Latency from start to done SHALL be 1 + WORD_W + (1..ACK_TIMEOUT) + 1 cycles; the minimum is WORD_W+3 cycles.

Reset
REQ-032 Reset SHALL put the FSM in IDLE with prgm_b=1, io_prgm_b=0, io_prgm_b_in=0, bit_out=0, busy=0, done=0, err=0, and all counters and the shift register at 0.
REQ-033 Reset SHALL take priority over start in the same cycle.
REQ-034 Reset in any state, including mid-SHIFT, SHALL abort the load with no done pulse; the partial chain contents are don't-care.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the default WORD_W and ACK_TIMEOUT constants, and the IO-group count of 8.
REQ-036 The block SHALL be a single module with no sub-modules; the counters and the shift register SHALL be inline.

Verification
REQ-037 The bench SHALL load cfg_word=16'hA5C3 -> bit_out over the 16 SHIFT cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; with the IO chain model attached, G0_S0=2'b10 and G7_S7=2'b11.
REQ-038 The bench SHALL return the acknowledge 1 cycle into WAIT_ACK -> done pulses exactly once, at start+WORD_W+3 cycles, then busy=0 and prgm_b=1.
REQ-039 The bench SHALL never return the acknowledge -> err=1 after 8 WAIT_ACK cycles, no done pulse, busy=0; a following start clears err and reloads.
REQ-040 The bench SHALL assert reset at SHIFT cycle 5 -> the next cycle shows all reset values and no done pulse; a restart then completes normally.
REQ-041 The bench SHALL pulse start again during SHIFT with a different cfg_word -> the pulse is ignored and the original bit sequence is unchanged.
REQ-042 The bench SHALL assert start and reset in the same cycle -> the FSM stays in IDLE with busy=0.
